// File: rtl/gf2_pivot_op_gen.sv
// Pivot cell of the GF(2) systemizer column: scans one column bit per row, picks the
// first 1 as pivot and issues PASS/ADD/SWAP row operations plus a final flush SWAP.
module gf2_pivot_op_gen #(
  parameter int ROWS = 8,
  parameter int IDXW = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            data_in,
  output logic [1:0]      op_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IDXW-1:0] pivot_idx,
  output logic            done,
  output logic            fail
);

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SWAP = 2'b10;
  localparam logic [IDXW-1:0] LAST_ROW = IDXW'(ROWS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    ELIM,
    FLUSH,
    DONE
  } state_t;

  state_t          state, state_nxt;
  logic [IDXW-1:0] row_cnt;
  logic            flush_sent, flush_sent_nxt;
  logic            out_free, accept, last_row;
  logic            load;
  logic [1:0]      load_op;
  logic            set_pivot, set_done, set_fail, clear_pass;

  // The output register can take a new op when empty or being drained this cycle.
  assign out_free = !out_valid || out_ready;
  assign in_ready = ((state == SCAN) || (state == ELIM)) && out_free;
  assign accept   = in_valid && in_ready;
  assign last_row = (row_cnt == LAST_ROW);

  always_comb begin
    state_nxt      = state;
    flush_sent_nxt = flush_sent;
    load           = 1'b0;
    load_op        = OP_PASS;
    set_pivot      = 1'b0;
    set_done       = 1'b0;
    set_fail       = 1'b0;
    clear_pass     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt  = SCAN;
          clear_pass = 1'b1;
        end
      end
      SCAN: begin
        if (accept) begin
          load = 1'b1;
          if (data_in) begin
            load_op   = OP_SWAP;
            set_pivot = 1'b1;
            state_nxt = last_row ? FLUSH : ELIM;
          end else begin
            load_op = OP_PASS;
            if (last_row) begin
              state_nxt = DONE;
              set_done  = 1'b1;
              set_fail  = 1'b1;
            end
          end
        end
      end
      ELIM: begin
        if (accept) begin
          load    = 1'b1;
          load_op = data_in ? OP_ADD : OP_PASS;
          if (last_row) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        // First issue the flush op, then wait for downstream to take it.
        if (!flush_sent) begin
          if (out_free) begin
            load           = 1'b1;
            load_op        = OP_SWAP;
            flush_sent_nxt = 1'b1;
          end
        end else if (out_ready) begin
          state_nxt      = DONE;
          set_done       = 1'b1;
          flush_sent_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      row_cnt    <= '0;
      flush_sent <= 1'b0;
      pivot_idx  <= '0;
      done       <= 1'b0;
      fail       <= 1'b0;
      op_out     <= OP_PASS;
      out_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      flush_sent <= flush_sent_nxt;
      if (clear_pass) begin
        row_cnt    <= '0;
        pivot_idx  <= '0;
        done       <= 1'b0;
        fail       <= 1'b0;
        flush_sent <= 1'b0;
      end else if (accept) begin
        row_cnt <= row_cnt + IDXW'(1);
      end
      if (set_pivot) pivot_idx <= row_cnt;
      if (set_done) begin
        done <= 1'b1;
        fail <= set_fail;
      end
      if (load) begin
        op_out    <= load_op;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
